elastic_pipeline: RTL

//  Valid/ready pipeline: DEPTH registered stages that carry data forward and carry

---
 rtl/skid_stage.sv | 77 +++++++
 rtl/elastic_pipeline.sv | 97 +++++++++
 2 files changed

// File: rtl/skid_stage.sv
// +--------------------------------------------------------------------------+
// | skid_stage : one 2-entry valid/ready stage (main + skid register).        |
// | up_ready_o comes straight from a flop, so there is no ready path through. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module skid_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  output logic             dn_valid_o,
  output logic [WIDTH-1:0] dn_data_o,
  input  logic             dn_ready_i
);

  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] m_data_q,  m_data_d;
  logic [WIDTH-1:0] s_data_q,  s_data_d;
  logic             w_up_xfer;
  logic             w_dn_xfer;

  assign up_ready_o = ~s_valid_q;
  assign dn_valid_o = m_valid_q;
  assign dn_data_o  = m_data_q;
  assign w_up_xfer  = up_valid_i & ~s_valid_q;
  assign w_dn_xfer  = m_valid_q & dn_ready_i;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (w_dn_xfer) begin
      // A full skid register blocks upstream, so it and up_xfer never coincide.
      if (s_valid_q) begin
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (w_up_xfer) begin
        m_data_d  = up_data_i;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (w_up_xfer) begin
      if (!m_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = up_data_i;
      end else begin
        s_valid_d = 1'b1;
        s_data_d  = up_data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    m_data_q <= m_data_d;
    s_data_q <= s_data_d;
  end

endmodule

`default_nettype wire

// File: rtl/elastic_pipeline.sv
// +--------------------------------------------------------------------------+
// | elastic_pipeline : DEPTH chained skid stages, full throughput, registered |
// | backpressure. ELASTIC_PIPE_OCC_EN adds the occupancy counter/port.        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module elastic_pipeline #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 1,
  localparam int OCC_W = (DEPTH > 0) ? $clog2(2*DEPTH+1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef ELASTIC_PIPE_OCC_EN
  ,
  output logic [OCC_W-1:0] occupancy
`endif
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign in_ready  = out_ready;
    end else begin : g_chain
      logic             w_valid [DEPTH+1];
      logic [WIDTH-1:0] w_data  [DEPTH+1];
      logic             w_ready [DEPTH+1];

      assign w_valid[0]     = in_valid;
      assign w_data[0]      = in_data;
      // Stage ready is high out of reset; hold the input closed while rst is up.
      assign in_ready       = w_ready[0] & ~rst;
      assign out_valid      = w_valid[DEPTH];
      assign out_data       = w_data[DEPTH];
      assign w_ready[DEPTH] = out_ready;

      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        skid_stage #(
          .WIDTH(WIDTH)
        ) u_stage (
          .clk        (clk),
          .rst        (rst),
          .up_valid_i (w_valid[i]),
          .up_data_i  (w_data[i]),
          .up_ready_o (w_ready[i]),
          .dn_valid_o (w_valid[i+1]),
          .dn_data_o  (w_data[i+1]),
          .dn_ready_i (w_ready[i+1])
        );
      end

      a_out_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
    end
  endgenerate

`ifdef ELASTIC_PIPE_OCC_EN
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;
  assign occupancy  = occ_q;

  always_comb begin
    occ_d = occ_q;
    if (w_in_xfer && !w_out_xfer) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!w_in_xfer && w_out_xfer) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  a_occ_sat: assert property (@(posedge clk) disable iff (rst)
    !(occ_q == OCC_W'(2*DEPTH) && w_in_xfer && !w_out_xfer));
`endif

endmodule

`default_nettype wire
